burst_mem_responder: RTL

Synthesizable responder for the CPU's physical-memory burst port: the memory side of the `pmem_*` interface driven by the cache/arbiter. It accepts line-aligned read and write requests and services each one as a four-beat, 64-bit burst after a programmable latency. Line data is held in an internal line-organized array. It replaces the behavioural burst memory in FPGA/emulation builds and gives the bench a deterministic, counted memory model.

---
 rtl/burst_mem_responder.sv | 119 +++++++++++
 1 files changed

// File: rtl/burst_mem_responder.sv
// burst_mem_responder: memory side of the pmem_* burst port.
// Each line-aligned request is served as four 64-bit beats after LATENCY cycles.
// Line data lives in an internal line-organised array; the array is not reset.
module burst_mem_responder #(
  parameter int unsigned LINES   = 256,
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pmem_read,
  input  logic        pmem_write,
  input  logic [31:0] pmem_address,
  input  logic [63:0] pmem_wdata,
  output logic [63:0] pmem_rdata,
  output logic        pmem_resp,
  output logic        proto_err,
  output logic [31:0] rd_bursts,
  output logic [31:0] wr_bursts
);

  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

  logic [63:0]   mem [LINES*4];
  state_t        state;
  logic [IW-1:0] idx;
  logic          op_wr;
  logic [CW-1:0] cnt;
  logic [1:0]    beat;

  logic          req;
  logic [IW-1:0] addr_idx;
  logic          wr_en;
  logic          unused_addr;

  assign req         = pmem_read | pmem_write;
  assign addr_idx    = pmem_address[5 +: IW];
  assign unused_addr = ^{pmem_address[4:0], pmem_address[31:5+IW]};
  // A beat is committed only if the request is still held at the edge ending it
  assign wr_en       = (state == BURST) && op_wr && req;

  // Line array write port: one beat per cycle during a write burst
  always_ff @(posedge clk) begin
    if (wr_en) mem[{idx, beat}] <= pmem_wdata;
  end

  // Burst FSM; pmem_resp/pmem_rdata are registered so they are loaded on the
  // edge that enters each beat rather than decoded from the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      op_wr      <= 1'b0;
      cnt        <= '0;
      beat       <= '0;
      pmem_resp  <= 1'b0;
      pmem_rdata <= '0;
      proto_err  <= 1'b0;
      rd_bursts  <= '0;
      wr_bursts  <= '0;
    end else begin
      case (state)
        IDLE: begin
          pmem_resp <= 1'b0;
          if (req) begin
            idx   <= addr_idx;
            op_wr <= pmem_write & ~pmem_read;
            beat  <= '0;
            if (pmem_read && pmem_write) proto_err <= 1'b1;
            if (LATENCY == 1) begin
              state     <= BURST;
              pmem_resp <= 1'b1;
              if (pmem_read) pmem_rdata <= mem[{addr_idx, 2'b00}];
            end else begin
              state <= WAIT;
              cnt   <= CW'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (!req) begin
            proto_err <= 1'b1;
            state     <= IDLE;
          end else if (cnt == CW'(1)) begin
            state     <= BURST;
            beat      <= '0;
            pmem_resp <= 1'b1;
            if (!op_wr) pmem_rdata <= mem[{idx, 2'b00}];
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        BURST: begin
          if (!req) begin
            proto_err <= 1'b1;
            state     <= IDLE;
            pmem_resp <= 1'b0;
          end else if (beat == 2'd3) begin
            state     <= DONE;
            pmem_resp <= 1'b0;
            if (op_wr) wr_bursts <= wr_bursts + 32'd1;
            else       rd_bursts <= rd_bursts + 32'd1;
          end else begin
            beat <= beat + 2'd1;
            if (!op_wr) pmem_rdata <= mem[{idx, beat + 2'd1}];
          end
        end
        DONE: begin
          pmem_resp <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
